edit_field_controller: RTL

EDIT_FIELD_CONTROLLER -- requirements
Module: edit_field_controller

---
 rtl/edit_field_controller_pkg.sv | 82 ++++++++
 rtl/edit_field_controller_if.sv | 39 +++
 rtl/edit_field_controller_bcd_wrap_step.sv | 34 +++
 rtl/edit_field_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/edit_field_controller_pkg.sv
// Shared definitions for the edit field controller.
// Holds the key scan codes, the FSM state encoding, the mode encoding,
// the per-mode BCD field limits, and lookup helpers for those limits.
package edit_field_controller_pkg;

  // Key scan codes
  localparam logic [7:0] KEY_F1    = 8'h05;
  localparam logic [7:0] KEY_F2    = 8'h06;
  localparam logic [7:0] KEY_F3    = 8'h04;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EDIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_TIME  = 2'd0,
    MODE_DATE  = 2'd1,
    MODE_TIMER = 2'd2
  } mode_e;

  // Field limits for time and timer modes (hour/min/sec)
  localparam logic [7:0] HMS_F0_MIN = 8'h00;
  localparam logic [7:0] HMS_F0_MAX = 8'h23;
  localparam logic [7:0] HMS_F1_MIN = 8'h00;
  localparam logic [7:0] HMS_F1_MAX = 8'h59;
  localparam logic [7:0] HMS_F2_MIN = 8'h00;
  localparam logic [7:0] HMS_F2_MAX = 8'h59;

  // Field limits for date mode (day/month/year); day is month-independent
  localparam logic [7:0] DATE_F0_MIN = 8'h01;
  localparam logic [7:0] DATE_F0_MAX = 8'h31;
  localparam logic [7:0] DATE_F1_MIN = 8'h01;
  localparam logic [7:0] DATE_F1_MAX = 8'h12;
  localparam logic [7:0] DATE_F2_MIN = 8'h00;
  localparam logic [7:0] DATE_F2_MAX = 8'h99;

  function automatic logic [7:0] field_min(mode_e m, logic [1:0] idx);
    logic [7:0] v;
    if (m == MODE_DATE) begin
      case (idx)
        2'd0:    v = DATE_F0_MIN;
        2'd1:    v = DATE_F1_MIN;
        default: v = DATE_F2_MIN;
      endcase
    end else begin
      case (idx)
        2'd0:    v = HMS_F0_MIN;
        2'd1:    v = HMS_F1_MIN;
        default: v = HMS_F2_MIN;
      endcase
    end
    return v;
  endfunction

  function automatic logic [7:0] field_max(mode_e m, logic [1:0] idx);
    logic [7:0] v;
    if (m == MODE_DATE) begin
      case (idx)
        2'd0:    v = DATE_F0_MAX;
        2'd1:    v = DATE_F1_MAX;
        default: v = DATE_F2_MAX;
      endcase
    end else begin
      case (idx)
        2'd0:    v = HMS_F0_MAX;
        2'd1:    v = HMS_F1_MAX;
        default: v = HMS_F2_MAX;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/edit_field_controller_if.sv
// Bus between the edit field controller and its surroundings
// (keyboard decoder, position counter, RTC interface).
//   key_code/got_code_tick : key scan code and its one-cycle strobe
//   posicion               : selected field index (3 is illegal)
//   cur_f0..2              : current BCD values of the selected mode
//   wr_done                : one-cycle write acknowledge
//   mode, edit_active      : controller status
//   pos_tick               : strobe to the position counter
//   f0..2, wr_req          : edit buffer and level write request
// slave = controller side, master = driving environment side.
interface edit_field_if #(
  parameter int N = 8,
  parameter int P = 2
) ();
  logic [N-1:0] key_code;
  logic         got_code_tick;
  logic [P-1:0] posicion;
  logic [7:0]   cur_f0;
  logic [7:0]   cur_f1;
  logic [7:0]   cur_f2;
  logic         wr_done;
  logic [1:0]   mode;
  logic         edit_active;
  logic         pos_tick;
  logic [7:0]   f0;
  logic [7:0]   f1;
  logic [7:0]   f2;
  logic         wr_req;

  modport slave (
    input  key_code, got_code_tick, posicion, cur_f0, cur_f1, cur_f2, wr_done,
    output mode, edit_active, pos_tick, f0, f1, f2, wr_req
  );

  modport master (
    output key_code, got_code_tick, posicion, cur_f0, cur_f1, cur_f2, wr_done,
    input  mode, edit_active, pos_tick, f0, f1, f2, wr_req
  );
endinterface

// File: rtl/edit_field_controller_bcd_wrap_step.sv
// Combinational single-step BCD counter with wrap-around.
//   i_value : current two-digit BCD value (assumed within [i_min, i_max])
//   i_min   : lowest legal BCD value
//   i_max   : highest legal BCD value
//   i_up    : 1 = increment, 0 = decrement
//   o_next  : stepped BCD value
module bcd_wrap_step (
  input  logic [7:0] i_value,
  input  logic [7:0] i_min,
  input  logic [7:0] i_max,
  input  logic       i_up,
  output logic [7:0] o_next
);

  always_comb begin
    o_next = i_value;
    if (i_up) begin
      if (i_value == i_max)
        o_next = i_min;
      else if (i_value[3:0] >= 4'h9)
        o_next = {i_value[7:4] + 4'h1, 4'h0};  // carry into tens digit
      else
        o_next = {i_value[7:4], i_value[3:0] + 4'h1};
    end else begin
      if (i_value == i_min)
        o_next = i_max;
      else if (i_value[3:0] == 4'h0)
        o_next = {i_value[7:4] - 4'h1, 4'h9};  // borrow from tens digit
      else
        o_next = {i_value[7:4], i_value[3:0] - 4'h1};
    end
  end

endmodule

// File: rtl/edit_field_controller.sv
// Edit field controller: keyboard-driven editor for the time, date and
// timer fields of an RTC. F1/F2/F3 select a mode and load its current
// values into an edit buffer; up/down step the selected field in BCD with
// wrap-around; enter requests a write to the RTC, esc abandons the edit.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : edit_field_if.slave (keys, position, current values, write
//          handshake, mode/status, edit buffer)
module edit_field_controller
  import edit_field_controller_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst,
  edit_field_if.slave  bus
);

  state_e     r_state;
  mode_e      r_mode;
  logic [7:0] r_f0, r_f1, r_f2;
  logic       r_wr_req;
  logic       r_edit_active;

  state_e     w_state_nxt;
  mode_e      w_mode_nxt;
  logic [7:0] w_f0_nxt, w_f1_nxt, w_f2_nxt;

  logic       w_key_up, w_key_down;
  logic       w_pos_valid;
  logic [1:0] w_idx;
  logic [7:0] w_sel;
  logic [7:0] w_min, w_max;
  logic [7:0] w_step;

  assign w_key_up    = (bus.key_code == N'(KEY_UP));
  assign w_key_down  = (bus.key_code == N'(KEY_DOWN));
  assign w_pos_valid = (bus.posicion < P'(3));
  assign w_idx       = bus.posicion[1:0];

  always_comb begin
    case (w_idx)
      2'd0:    w_sel = r_f0;
      2'd1:    w_sel = r_f1;
      default: w_sel = r_f2;
    endcase
  end

  assign w_min = field_min(r_mode, w_idx);
  assign w_max = field_max(r_mode, w_idx);

  bcd_wrap_step u_step (
    .i_value (w_sel),
    .i_min   (w_min),
    .i_max   (w_max),
    .i_up    (w_key_up),
    .o_next  (w_step)
  );

  // Navigation keys go straight to the position counter, only while editing.
  assign bus.pos_tick = bus.got_code_tick && (r_state == ST_EDIT) &&
                        ((bus.key_code == N'(KEY_RIGHT)) ||
                         (bus.key_code == N'(KEY_LEFT)));

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_f0_nxt    = r_f0;
    w_f1_nxt    = r_f1;
    w_f2_nxt    = r_f2;
    case (r_state)
      ST_IDLE: begin
        if (bus.got_code_tick) begin
          if (bus.key_code == N'(KEY_F1)) begin
            w_mode_nxt  = MODE_TIME;
            w_state_nxt = ST_LOAD;
          end else if (bus.key_code == N'(KEY_F2)) begin
            w_mode_nxt  = MODE_DATE;
            w_state_nxt = ST_LOAD;
          end else if (bus.key_code == N'(KEY_F3)) begin
            w_mode_nxt  = MODE_TIMER;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // mode is already registered here, so cur_f reflects the new mode
        w_f0_nxt    = bus.cur_f0;
        w_f1_nxt    = bus.cur_f1;
        w_f2_nxt    = bus.cur_f2;
        w_state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        if (bus.got_code_tick) begin
          if ((w_key_up || w_key_down) && w_pos_valid) begin
            case (w_idx)
              2'd0:    w_f0_nxt = w_step;
              2'd1:    w_f1_nxt = w_step;
              default: w_f2_nxt = w_step;
            endcase
          end else if (bus.key_code == N'(KEY_ENTER)) begin
            w_state_nxt = ST_WRITE;
          end else if (bus.key_code == N'(KEY_ESC)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.wr_done)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_TIME;
      r_f0          <= 8'h00;
      r_f1          <= 8'h00;
      r_f2          <= 8'h00;
      r_wr_req      <= 1'b0;
      r_edit_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_f0          <= w_f0_nxt;
      r_f1          <= w_f1_nxt;
      r_f2          <= w_f2_nxt;
      r_wr_req      <= (w_state_nxt == ST_WRITE);
      r_edit_active <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_EDIT);
    end
  end

  assign bus.mode        = r_mode;
  assign bus.f0          = r_f0;
  assign bus.f1          = r_f1;
  assign bus.f2          = r_f2;
  assign bus.wr_req      = r_wr_req;
  assign bus.edit_active = r_edit_active;

endmodule
